ni_inject_queue: RTL
====================

Name: ni_inject_queue

Overview:
- Network-interface injection stage between an IP block's packet output and its router's local input port.
- Accepts single-cycle packet_t pulses, buffers them in a FIFO, and computes the XY-routing output direction at enqueue.
- Presents the head packet and its direction to the router over a valid/ready handshake.
- Counts, rather than stalls, packets that arrive while the FIFO is full; the producer does not hold valid.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the statistics/drop counters.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- X  input  8  local router x coordinate.
- Y  input  8  local router y coordinate.
- pkt_in  input  packet_t  packet from IP block; fields data[31:0], src[15:0] {x,y}, dst[15:0] {x,y}, timestamp[31:0], valid.
- valid_in  input  1  pkt_in qualifier, single-cycle pulse.
- ready_out  output  1  to IP block: FIFO not full.
- pkt_out  output  packet_t  head packet to router.
- dir_out  output  3  routing direction of head packet.
- valid_out  output  1  head valid.
- ready_in  input  1  router accepts head this cycle.
- drop_cnt  output  CNT_W  packets lost to full FIFO, saturating.
- occupancy  output  $clog2(DEPTH)+1  current entry count.
- accept_cnt  output  CNT_W  accepted packets (NI_STATS_EN only).
- fwd_cnt  output  CNT_W  forwarded packets (NI_STATS_EN only).
- max_occ  output  $clog2(DEPTH)+1  high-water mark (NI_STATS_EN only).

Behaviour:
- Reset (sync, rst=1 at posedge): wr/rd pointers=0, occupancy=0, valid_out=0, ready_out=1, pkt_out=0, dir_out=0, all counters=0. FIFO storage is not cleared. Reset mid-operation discards all queued packets; the drop counter does not count them.
- ready_out = (occupancy != DEPTH), derived from the occupancy register only, never from ready_in.
- Push: valid_in && ready_out writes {pkt_in with valid forced to 1, dir} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Drop: valid_in && !ready_out discards the packet and increments drop_cnt, saturating at all-ones.
- Pop: valid_out && ready_in advances rd_ptr, wrapping modulo DEPTH.
- Show-ahead output: valid_out = (occupancy != 0); pkt_out/dir_out = entry[rd_ptr] combinationally from storage.
- Latency: a packet pushed into an empty FIFO appears on valid_out the next cycle (1 cycle). There is no combinational valid_in-to-valid_out path.
- Simultaneous push and pop: occupancy is unchanged. When full, a pop in the same cycle does not enable a push; the incoming packet is dropped.
- Pop while empty is impossible because valid_out=0.
- Direction, computed from pkt_in.dst at enqueue with dx=dst[15:8], dy=dst[7:0], unsigned compares:
  - dx>X: 1 EAST
  - dx<X: 2 WEST
  - else dy<Y: 3 NORTH
  - else dy>Y: 4 SOUTH
  - else: 0 LOCAL
  - Codes 5-7 are unused.
- pkt_out holds stable while valid_out=1 and ready_in=0.

Optional Feature:
- Macro: NI_STATS_EN.
- Defined:
  - accept_cnt increments on each push.
  - fwd_cnt increments on each pop.
  - Both saturate at all-ones.
  - max_occ = max(max_occ, next occupancy), updated every cycle.
  - All three reset to 0.
- Undefined: accept_cnt, fwd_cnt and max_occ are tied to 0 and no registers are inferred. drop_cnt and occupancy are always present.

Test Plan:
- Reset, then X=1, Y=1, one push with dst=16'h0201, ready_in=1 -> next cycle valid_out=1, dir_out=1 (EAST), pkt_out.valid=1; the cycle after, valid_out=0 and occupancy=0.
- Direction sweep at X=2, Y=2 with dst 0x0102, 0x0201, 0x0203, 0x0202 -> dir_out 2, 3, 4, 0 respectively, in FIFO order.
- ready_in=0, push 6 packets (DEPTH=4) -> ready_out=0 after the 4th push, drop_cnt=2, occupancy=4. Release ready_in -> data 0..3 emerge in order, 1 per cycle.
- Full FIFO, push and pop in the same cycle -> push dropped (drop_cnt+1), occupancy=3. Next cycle ready_out=1 and a push is accepted.
- Assert rst while 3 entries are queued -> next cycle valid_out=0, occupancy=0, drop_cnt=0. A subsequent push emerges with a correct payload.
- With NI_STATS_EN: 10 pushes, 10 pops, peak 3 -> accept_cnt=10, fwd_cnt=10, max_occ=3. Without NI_STATS_EN, all three read 0.

Source files
------------

// File: rtl/ni_inject_queue.sv
// NI injection queue: buffers IP packets, tags each with its XY route direction at enqueue,
// and drops (counts) packets arriving while full. Optional statistics under NI_STATS_EN.
package ni_inject_queue_pkg;
    typedef struct packed {
        logic [31:0] data;
        logic [15:0] src;
        logic [15:0] dst;
        logic [31:0] timestamp;
        logic        valid;
    } packet_t;
endpackage

module ni_inject_queue
    import ni_inject_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 X,
    input  logic [7:0]                 Y,
    input  packet_t                    pkt_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    output packet_t                    pkt_out,
    output logic [2:0]                 dir_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           accept_cnt,
    output logic [CNT_W-1:0]           fwd_cnt,
    output logic [$clog2(DEPTH):0]     max_occ
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;

    localparam logic [2:0] DIR_LOCAL = 3'd0;
    localparam logic [2:0] DIR_EAST  = 3'd1;
    localparam logic [2:0] DIR_WEST  = 3'd2;
    localparam logic [2:0] DIR_NORTH = 3'd3;
    localparam logic [2:0] DIR_SOUTH = 3'd4;

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]    occ_q, occ_d;
    logic [CNT_W-1:0] drop_q;
    packet_t          mem_q [DEPTH];
    logic [2:0]       dir_mem_q [DEPTH];

    logic       push, pop;
    logic [7:0] dx, dy;
    logic [2:0] dir_in;
    packet_t    pkt_wr;

    assign ready_out = (occ_q != OW'(DEPTH));
    assign valid_out = (occ_q != '0);
    assign push      = valid_in && ready_out;
    assign pop       = valid_out && ready_in;

    always_comb begin
        dx     = pkt_in.dst[15:8];
        dy     = pkt_in.dst[7:0];
        dir_in = DIR_LOCAL;
        if (dx > X)      dir_in = DIR_EAST;
        else if (dx < X) dir_in = DIR_WEST;
        else if (dy < Y) dir_in = DIR_NORTH;
        else if (dy > Y) dir_in = DIR_SOUTH;
    end

    always_comb begin
        pkt_wr       = pkt_in;
        pkt_wr.valid = 1'b1;
    end

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            drop_q   <= '0;
        end else begin
            occ_q <= occ_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (valid_in && !ready_out && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
        end
    end

    // Storage is deliberately left out of reset; occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q]     <= pkt_wr;
            dir_mem_q[wr_ptr_q] <= dir_in;
        end
    end

    // Gate the head with valid_out so an empty queue presents zeros, not stale storage.
    assign pkt_out   = valid_out ? mem_q[rd_ptr_q] : '0;
    assign dir_out   = valid_out ? dir_mem_q[rd_ptr_q] : DIR_LOCAL;
    assign drop_cnt  = drop_q;
    assign occupancy = occ_q;

`ifdef NI_STATS_EN
    logic [CNT_W-1:0] accept_q, fwd_q;
    logic [OW-1:0]    max_occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            accept_q  <= '0;
            fwd_q     <= '0;
            max_occ_q <= '0;
        end else begin
            if (push && (accept_q != '1)) accept_q <= accept_q + CNT_W'(1);
            if (pop && (fwd_q != '1))     fwd_q    <= fwd_q + CNT_W'(1);
            if (occ_d > max_occ_q)        max_occ_q <= occ_d;
        end
    end

    assign accept_cnt = accept_q;
    assign fwd_cnt    = fwd_q;
    assign max_occ    = max_occ_q;
`else
    assign accept_cnt = '0;
    assign fwd_cnt    = '0;
    assign max_occ    = '0;
`endif

endmodule
